bcd_countdown_timer: RTL

//  Parametrised BCD mm:ss countdown/count-up timer core with built-in prescaler, input

---
 rtl/bcd_countdown_timer.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/bcd_countdown_timer.sv
// BCD mm:ss countdown / count-up timer core: prescaler, load clamping,
// pause/resume, auto-reload and a timed, flashing alarm.
//
// Ports:
//   clk, reset            clock; asynchronous active-high reset
//   set                   1-cycle pulse: load target/count from load_min/load_sec
//   start_stop            1-cycle pulse: start / pause / resume / acknowledge
//   up_mode               sampled on set: 1 = count 00:00 up to the target
//   reload_en             level: on expiry reload and keep running
//   load_min, load_sec    BCD load value (clamped to a legal time)
//   min_bcd, sec_bcd      current count, BCD
//   running, done         state is RUN / ALARM
//   flash                 blink pattern while in ALARM, else 0
//   alarm_pulse           1-cycle pulse on every expiry

module bcd_countdown_timer #(
    parameter int TICK_DIV   = 50000000,
    parameter int FLASH_DIV  = 25000000,
    parameter int MIN_DIGITS = 2,
    parameter int ALARM_SECS = 0
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    set,
    input  logic                    start_stop,
    input  logic                    up_mode,
    input  logic                    reload_en,
    input  logic [4*MIN_DIGITS-1:0] load_min,
    input  logic [7:0]              load_sec,
    output logic [4*MIN_DIGITS-1:0] min_bcd,
    output logic [7:0]              sec_bcd,
    output logic                    running,
    output logic                    done,
    output logic                    flash,
    output logic                    alarm_pulse
);

    // Time is held as one nibble vector: [3:0] sec ones, [7:4] sec tens,
    // then minute digits upward.
    localparam int ND   = MIN_DIGITS + 2;
    localparam int TW   = 4 * ND;
    localparam int PW   = $clog2(TICK_DIV);
    localparam int FW   = (FLASH_DIV > 1) ? $clog2(FLASH_DIV) : 1;
    localparam int ACYC = (ALARM_SECS > 0) ? ALARM_SECS * TICK_DIV : 1;
    localparam int AW   = (ACYC > 1) ? $clog2(ACYC) : 1;

    typedef enum logic [1:0] {IDLE, RUN, PAUSE, ALARM} state_t;

    state_t         state;
    logic [TW-1:0]  count;
    logic [TW-1:0]  target;
    logic           up_q;
    logic [PW-1:0]  presc;
    logic [FW-1:0]  fcnt;
    logic [AW-1:0]  acnt;

    logic [TW-1:0]  load_val;
    logic [TW-1:0]  step_val;
    logic           tick;
    logic           expire;
    logic           auto_exit;

    // Sec tens saturates at 5, every other digit at 9.
    function automatic logic [TW-1:0] clamp(input logic [TW-1:0] v);
        logic [TW-1:0] r;
        logic [3:0]    lim;
        r = v;
        for (int i = 0; i < ND; i++) begin
            lim = (i == 1) ? 4'd5 : 4'd9;
            if (v[4*i +: 4] > lim)
                r[4*i +: 4] = lim;
        end
        return r;
    endfunction

    // One BCD step with ripple carry/borrow; the carry out of the top
    // minute digit is dropped, so the count wraps.
    function automatic logic [TW-1:0] bcd_step(input logic [TW-1:0] v,
                                               input logic up);
        logic [TW-1:0] r;
        logic          c;
        logic [3:0]    d;
        logic [3:0]    lim;
        r = v;
        c = 1'b1;
        for (int i = 0; i < ND; i++) begin
            lim = (i == 1) ? 4'd5 : 4'd9;
            d   = v[4*i +: 4];
            if (c) begin
                if (up) begin
                    if (d >= lim) begin
                        r[4*i +: 4] = 4'd0;
                    end else begin
                        r[4*i +: 4] = d + 4'd1;
                        c = 1'b0;
                    end
                end else begin
                    if (d == 4'd0) begin
                        r[4*i +: 4] = lim;
                    end else begin
                        r[4*i +: 4] = d - 4'd1;
                        c = 1'b0;
                    end
                end
            end
        end
        return r;
    endfunction

    assign load_val  = clamp({load_min, load_sec});
    assign step_val  = bcd_step(count, up_q);
    assign tick      = (presc == PW'(TICK_DIV - 1));
    assign expire    = up_q ? (step_val == target) : (step_val == '0);
    assign auto_exit = (ALARM_SECS > 0) && (acnt == AW'(ACYC - 1));

    assign min_bcd = count[TW-1:8];
    assign sec_bcd = count[7:0];
    assign running = (state == RUN);
    assign done    = (state == ALARM);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            count       <= '0;
            target      <= '0;
            up_q        <= 1'b0;
            presc       <= '0;
            fcnt        <= '0;
            acnt        <= '0;
            flash       <= 1'b0;
            alarm_pulse <= 1'b0;
        end else begin
            alarm_pulse <= 1'b0;

            // A load is honoured everywhere except while running.
            if (set && state != RUN) begin
                target <= load_val;
                up_q   <= up_mode;
                count  <= up_mode ? '0 : load_val;
            end

            unique case (state)
                IDLE: begin
                    if (!set && start_stop && target != '0) begin
                        state <= RUN;
                        presc <= '0;
                    end
                end
                RUN: begin
                    if (start_stop && !set) begin
                        state <= PAUSE;
                    end else if (tick) begin
                        presc <= '0;
                        if (expire) begin
                            alarm_pulse <= 1'b1;
                            if (reload_en) begin
                                // Skip the final value so it is never shown.
                                count <= up_q ? '0 : target;
                            end else begin
                                count <= step_val;
                                state <= ALARM;
                                flash <= 1'b1;
                                fcnt  <= '0;
                                acnt  <= '0;
                            end
                        end else begin
                            count <= step_val;
                        end
                    end else begin
                        presc <= presc + 1'b1;
                    end
                end
                PAUSE: begin
                    if (set)
                        state <= IDLE;
                    else if (start_stop)
                        state <= RUN;
                end
                ALARM: begin
                    if (set || start_stop || auto_exit) begin
                        state <= IDLE;
                        flash <= 1'b0;
                    end else begin
                        acnt <= acnt + 1'b1;
                        if (fcnt == FW'(FLASH_DIV - 1)) begin
                            fcnt  <= '0;
                            flash <= ~flash;
                        end else begin
                            fcnt <= fcnt + 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
